// File: rtl/tcpc_pkg.sv
// Shared TCPC protocol-layer types: GoodCRC transmitter states and the
// message header field positions (also used by the Rx header parser).
package tcpc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BUS,
    ST_SEND_B0,
    ST_SEND_B1,
    ST_WAIT_DONE
  } goodcrc_tx_state_t;

  localparam logic [4:0] MSG_TYPE_GOODCRC = 5'b00001;

  localparam int HDR_MSG_TYPE_LSB = 0;
  localparam int HDR_DATA_ROLE    = 5;
  localparam int HDR_SPEC_REV_LSB = 6;
  localparam int HDR_POWER_ROLE   = 8;
  localparam int HDR_MSG_ID_LSB   = 9;
  localparam int HDR_NUM_DO_LSB   = 12;
  localparam int HDR_EXTENDED     = 15;

  function automatic logic [15:0] buildGoodCrcHdr(
    input logic [2:0] msgId,
    input logic [1:0] specRev,
    input logic       powerRole,
    input logic       dataRole
  );
    logic [15:0] h;
    h = '0;
    h[HDR_MSG_TYPE_LSB +: 5] = MSG_TYPE_GOODCRC;
    h[HDR_DATA_ROLE]         = dataRole;
    h[HDR_SPEC_REV_LSB +: 2] = specRev;
    h[HDR_POWER_ROLE]        = powerRole;
    h[HDR_MSG_ID_LSB +: 3]   = msgId;
    h[HDR_NUM_DO_LSB +: 3]   = 3'b000;
    h[HDR_EXTENDED]          = 1'b0;
    return h;
  endfunction

endpackage

// File: rtl/goodcrc_tx.sv
// GoodCRC transmitter: builds the acknowledgement header for a received
// message, streams it as two bytes to the PHY and reports complete/discard.
module goodcrc_tx
  import tcpc_pkg::*;
#(
  parameter int BUS_IDLE_TIMEOUT = 16,
  parameter int DONE_TIMEOUT     = 64,
  parameter int CNT_W            = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_msg_valid,
  input  logic [2:0] rx_msg_id,
  input  logic [1:0] cfg_spec_rev,
  input  logic       cfg_power_role,
  input  logic       cfg_data_role,
  input  logic       bus_idle,
  input  logic       phy_tx_ready,
  input  logic       phy_tx_done,
  output logic [7:0] phy_tx_data,
  output logic       phy_tx_valid,
  output logic       phy_tx_last,
  output logic       tx,
  output logic       GoodCRC_Transmission_complete,
  output logic       GoodCRC_Message_discarded_bus_Idle
);

  localparam logic [CNT_W-1:0] BUS_LAST  = CNT_W'(BUS_IDLE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TIMEOUT - 1);

  goodcrc_tx_state_t state, stateNxt;
  logic [CNT_W-1:0]  cnt, cntNxt;
  logic [15:0]       hdr, hdrNxt, newHdr;
  logic              completeQ, discardQ, completeNxt, discardNxt;
  logic              hs;

  assign newHdr = buildGoodCrcHdr(rx_msg_id, cfg_spec_rev, cfg_power_role, cfg_data_role);
  assign hs     = phy_tx_valid & phy_tx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hdr       <= '0;
      completeQ <= 1'b0;
      discardQ  <= 1'b0;
    end else begin
      state     <= stateNxt;
      cnt       <= cntNxt;
      hdr       <= hdrNxt;
      completeQ <= completeNxt;
      discardQ  <= discardNxt;
    end
  end

  always_comb begin
    stateNxt    = state;
    cntNxt      = cnt;
    hdrNxt      = hdr;
    completeNxt = 1'b0;
    discardNxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_msg_valid) begin
          hdrNxt   = newHdr;
          cntNxt   = '0;
          stateNxt = ST_WAIT_BUS;
        end
      end
      ST_WAIT_BUS: begin
        // A newer message supersedes the pending ack, even if the bus is idle.
        if (rx_msg_valid) begin
          discardNxt = 1'b1;
          hdrNxt     = newHdr;
          cntNxt     = '0;
        end else if (bus_idle) begin
          cntNxt   = '0;
          stateNxt = ST_SEND_B0;
        end else if (cnt == BUS_LAST) begin
          discardNxt = 1'b1;
          cntNxt     = '0;
          stateNxt   = ST_IDLE;
        end else begin
          cntNxt = cnt + 1'b1;
        end
      end
      ST_SEND_B0: begin
        if (hs) stateNxt = ST_SEND_B1;
      end
      ST_SEND_B1: begin
        if (hs) begin
          cntNxt   = '0;
          stateNxt = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // A done arriving on the timeout cycle still counts as success.
        if (phy_tx_done) begin
          completeNxt = 1'b1;
          cntNxt      = '0;
          stateNxt    = ST_IDLE;
        end else if (cnt == DONE_LAST) begin
          discardNxt = 1'b1;
          cntNxt     = '0;
          stateNxt   = ST_IDLE;
        end else begin
          cntNxt = cnt + 1'b1;
        end
      end
      default: stateNxt = ST_IDLE;
    endcase
  end

  always_comb begin
    phy_tx_valid = (state == ST_SEND_B0) || (state == ST_SEND_B1);
    phy_tx_last  = (state == ST_SEND_B1);
    tx           = phy_tx_valid || (state == ST_WAIT_DONE);
    phy_tx_data  = 8'h00;
    if (state == ST_SEND_B0)      phy_tx_data = hdr[7:0];
    else if (state == ST_SEND_B1) phy_tx_data = hdr[15:8];
  end

  assign GoodCRC_Transmission_complete      = completeQ;
  assign GoodCRC_Message_discarded_bus_Idle = discardQ;

endmodule

// File: tb/tb_goodcrc_tx.sv
// Scoreboard bench for goodcrc_tx: stimulus queues expected bytes/events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_goodcrc_tx;

  logic       clk, reset;
  logic       rx_msg_valid;
  logic [2:0] rx_msg_id;
  logic [1:0] cfg_spec_rev;
  logic       cfg_power_role, cfg_data_role;
  logic       bus_idle, phy_tx_ready, phy_tx_done;
  logic [7:0] phy_tx_data;
  logic       phy_tx_valid, phy_tx_last, tx;
  logic       GoodCRC_Transmission_complete, GoodCRC_Message_discarded_bus_Idle;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_byte_t;

  localparam logic [1:0] EV_COMPLETE = 2'b10;
  localparam logic [1:0] EV_DISCARD  = 2'b01;

  exp_byte_t  expByteQ[$];
  logic [1:0] expEvQ[$];
  int checks   = 0;
  int failures = 0;

  goodcrc_tx #(.BUS_IDLE_TIMEOUT(16), .DONE_TIMEOUT(64), .CNT_W(8)) dut (
    .clk                                (clk),
    .reset                              (reset),
    .rx_msg_valid                       (rx_msg_valid),
    .rx_msg_id                          (rx_msg_id),
    .cfg_spec_rev                       (cfg_spec_rev),
    .cfg_power_role                     (cfg_power_role),
    .cfg_data_role                      (cfg_data_role),
    .bus_idle                           (bus_idle),
    .phy_tx_ready                       (phy_tx_ready),
    .phy_tx_done                        (phy_tx_done),
    .phy_tx_data                        (phy_tx_data),
    .phy_tx_valid                       (phy_tx_valid),
    .phy_tx_last                        (phy_tx_last),
    .tx                                 (tx),
    .GoodCRC_Transmission_complete      (GoodCRC_Transmission_complete),
    .GoodCRC_Message_discarded_bus_Idle (GoodCRC_Message_discarded_bus_Idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic sendMsg(input logic [2:0] id, input logic [1:0] rev, input logic pr, input logic dr);
    sync();
    rx_msg_id = id; cfg_spec_rev = rev; cfg_power_role = pr; cfg_data_role = dr;
    rx_msg_valid = 1'b1;
    sync();
    rx_msg_valid = 1'b0;
  endtask

  task automatic pushBytes(input logic [7:0] b0, input logic [7:0] b1);
    expByteQ.push_back('{data: b0, last: 1'b0});
    expByteQ.push_back('{data: b1, last: 1'b1});
  endtask

  // Returns at the negedge of the first cycle with tx high and no byte offered.
  task automatic waitDoneState();
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(tx && !phy_tx_valid) && n < 50);
    if (!(tx && !phy_tx_valid)) check("wait_done_state_timeout", 32'(tx), 32'(!tx));
  endtask

  task automatic waitValid();
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while (!phy_tx_valid && n < 50);
    if (!phy_tx_valid) check("wait_valid_timeout", 32'(phy_tx_valid), 32'd1);
  endtask

  task automatic pulseDone();
    sync();
    phy_tx_done = 1'b1;
    sync();
    phy_tx_done = 1'b0;
    @(negedge clk);
    check("tx_low_after_event", 32'(tx), 32'd0);
  endtask

  // Monitor: compare every byte handshake and event pulse against the queues.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (phy_tx_valid && phy_tx_ready) begin
        if (expByteQ.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_byte actual=0x%0h last=%0d expected=none", phy_tx_data, phy_tx_last);
        end else begin
          exp_byte_t e;
          e = expByteQ.pop_front();
          check("byte_data", 32'(phy_tx_data), 32'(e.data));
          check("byte_last", 32'(phy_tx_last), 32'(e.last));
        end
      end
      if (GoodCRC_Transmission_complete || GoodCRC_Message_discarded_bus_Idle) begin
        logic [1:0] ev, expEv;
        ev = {GoodCRC_Transmission_complete, GoodCRC_Message_discarded_bus_Idle};
        if (expEvQ.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_event actual=%b expected=none", ev);
        end else begin
          expEv = expEvQ.pop_front();
          check("event_kind", 32'(ev), 32'(expEv));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    rx_msg_valid = 0; rx_msg_id = 0; cfg_spec_rev = 0; cfg_power_role = 0; cfg_data_role = 0;
    bus_idle = 0; phy_tx_ready = 0; phy_tx_done = 0;

    @(negedge clk);
    check("rst_outputs", 32'({phy_tx_data, phy_tx_valid, phy_tx_last, tx,
          GoodCRC_Transmission_complete, GoodCRC_Message_discarded_bus_Idle}), 32'd0);
    sync();
    reset = 1'b0;

    // Basic send
    sync();
    bus_idle = 1; phy_tx_ready = 1;
    pushBytes(8'h81, 8'h07);
    expEvQ.push_back(EV_COMPLETE);
    sendMsg(3'd3, 2'b10, 1'b1, 1'b0);
    waitDoneState();
    sync(); sync();
    pulseDone();

    // Backpressure on byte0
    sync();
    phy_tx_ready = 0;
    pushBytes(8'h81, 8'h07);
    expEvQ.push_back(EV_COMPLETE);
    sendMsg(3'd3, 2'b10, 1'b1, 1'b0);
    waitValid();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_valid", 32'(phy_tx_valid), 32'd1);
      check("bp_data", 32'(phy_tx_data), 32'h81);
      check("bp_last", 32'(phy_tx_last), 32'd0);
    end
    sync();
    phy_tx_ready = 1;
    waitDoneState();
    pulseDone();

    // Bus busy: discard 16 cycles after entering WAIT_BUS
    sync();
    bus_idle = 0;
    expEvQ.push_back(EV_DISCARD);
    sendMsg(3'd1, 2'b10, 1'b0, 1'b0);
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      check("busy_no_valid", 32'(phy_tx_valid), 32'd0);
      check("busy_discard_timing", 32'(GoodCRC_Message_discarded_bus_Idle), 32'(i == 16));
    end
    repeat (4) sync();
    bus_idle = 1;
    repeat (3) @(negedge clk);
    check("busy_idle_after", 32'(phy_tx_valid), 32'd0);

    // Done timeout: discard after 64 cycles in WAIT_DONE
    sync();
    pushBytes(8'h81, 8'h07);
    expEvQ.push_back(EV_DISCARD);
    sendMsg(3'd3, 2'b10, 1'b1, 1'b0);
    waitDoneState();
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (i == 63) begin
        check("dto_tx_before", 32'(tx), 32'd1);
        check("dto_no_early_discard", 32'(GoodCRC_Message_discarded_bus_Idle), 32'd0);
      end
      if (i == 64) begin
        check("dto_discard", 32'(GoodCRC_Message_discarded_bus_Idle), 32'd1);
        check("dto_tx_low", 32'(tx), 32'd0);
      end
    end

    // Done on the timeout cycle: complete wins
    sync();
    pushBytes(8'h81, 8'h07);
    expEvQ.push_back(EV_COMPLETE);
    sendMsg(3'd3, 2'b10, 1'b1, 1'b0);
    waitDoneState();
    repeat (63) @(posedge clk);
    #1;
    phy_tx_done = 1;
    sync();
    phy_tx_done = 0;
    @(negedge clk);
    check("race_complete", 32'(GoodCRC_Transmission_complete), 32'd1);
    check("race_no_discard", 32'(GoodCRC_Message_discarded_bus_Idle), 32'd0);

    // Preemption in WAIT_BUS: latest message wins
    sync();
    bus_idle = 0;
    expEvQ.push_back(EV_DISCARD);
    pushBytes(8'h61, 8'h0B);
    expEvQ.push_back(EV_COMPLETE);
    sendMsg(3'd3, 2'b10, 1'b1, 1'b0);
    repeat (3) sync();
    sendMsg(3'd5, 2'b01, 1'b1, 1'b1);
    repeat (2) sync();
    bus_idle = 1;
    waitDoneState();
    pulseDone();

    // Reset in SEND_B1
    sync();
    phy_tx_ready = 0;
    expByteQ.push_back('{data: 8'h81, last: 1'b0});
    sendMsg(3'd3, 2'b10, 1'b1, 1'b0);
    waitValid();
    check("rst_b0_data", 32'(phy_tx_data), 32'h81);
    sync();
    phy_tx_ready = 1;
    sync();
    phy_tx_ready = 0;
    @(negedge clk);
    check("rst_b1_data", 32'(phy_tx_data), 32'h07);
    check("rst_b1_last", 32'(phy_tx_last), 32'd1);
    #2 reset = 1;
    #1;
    check("rst_async_outputs", 32'({phy_tx_data, phy_tx_valid, phy_tx_last, tx,
          GoodCRC_Transmission_complete, GoodCRC_Message_discarded_bus_Idle}), 32'd0);
    sync();
    reset = 0;
    repeat (3) @(negedge clk);
    check("rst_quiet_tx", 32'(tx), 32'd0);

    // Normal operation after reset
    sync();
    phy_tx_ready = 1;
    pushBytes(8'h01, 8'h0C);
    expEvQ.push_back(EV_COMPLETE);
    sendMsg(3'd6, 2'b00, 1'b0, 1'b0);
    waitDoneState();
    pulseDone();

    repeat (5) @(negedge clk);
    check("byte_queue_empty", 32'(expByteQ.size()), 32'd0);
    check("event_queue_empty", 32'(expEvQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/goodcrc_tx.md
Name: goodcrc_tx

Overview:
Protocol-layer GoodCRC transmitter for the TCPC receive path. When a valid incoming message needs acknowledgement, it builds the 16-bit GoodCRC header and serializes it as two bytes to the PHY transmitter over a valid/ready handshake. It reports the outcome to the downstream Rx state machine through the GoodCRC_Transmission_complete and GoodCRC_Message_discarded_bus_Idle event pulses, and drives its tx busy indication.

Parameters:
BUS_IDLE_TIMEOUT, 16, cycles to wait for bus_idle before discarding the GoodCRC
DONE_TIMEOUT, 64, cycles to wait for phy_tx_done after the last byte before discarding
CNT_W, 8, width of the shared timeout counter; must hold max(BUS_IDLE_TIMEOUT, DONE_TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
rx_msg_valid  in  1  one-cycle pulse: a valid message was received and needs a GoodCRC
rx_msg_id  in  3  MessageID of the received message; sampled with rx_msg_valid
cfg_spec_rev  in  2  Specification Revision field; sampled with rx_msg_valid
cfg_power_role  in  1  Port Power Role; sampled with rx_msg_valid
cfg_data_role  in  1  Port Data Role; sampled with rx_msg_valid
bus_idle  in  1  CC line idle, from the PHY
phy_tx_ready  in  1  PHY accepts a byte this cycle
phy_tx_done  in  1  one-cycle pulse: PHY finished sending the packet, including CRC and EOP
phy_tx_data  out  8  header byte to the PHY
phy_tx_valid  out  1  phy_tx_data is valid
phy_tx_last  out  1  marks the final byte of the packet
tx  out  1  high while a GoodCRC is being transmitted
GoodCRC_Transmission_complete  out  1  one-cycle pulse on success
GoodCRC_Message_discarded_bus_Idle  out  1  one-cycle pulse on discard

Behaviour:
- Reset (asynchronous, active-high). All outputs are 0: phy_tx_data=8'h00, phy_tx_valid=0, phy_tx_last=0, tx=0, both event pulses 0. State is IDLE, counter is 0, header register is 0. Reset mid-packet drops the transfer immediately and emits no event pulse.
- Header layout, latched when rx_msg_valid=1:
  - [4:0]=5'b00001 (GoodCRC)
  - [5]=cfg_data_role
  - [7:6]=cfg_spec_rev
  - [8]=cfg_power_role
  - [11:9]=rx_msg_id
  - [14:12]=3'b000
  - [15]=0
- Byte order: byte0=header[7:0] is sent first, byte1=header[15:8] second.
- States: IDLE, WAIT_BUS, SEND_B0, SEND_B1, WAIT_DONE.
- IDLE: rx_msg_valid -> latch header, clear counter, go to WAIT_BUS on the next edge.
- WAIT_BUS:
  - bus_idle=1 -> SEND_B0, clear counter.
  - Otherwise the counter increments each cycle.
  - Counter reaches BUS_IDLE_TIMEOUT-1 while bus_idle=0 -> pulse discard for 1 cycle, go to IDLE.
  - A new rx_msg_valid here (latest wins) -> pulse discard for the old message, latch the new header, restart the counter, stay in WAIT_BUS.
- SEND_B0: phy_tx_valid=1, phy_tx_data=byte0, tx=1. Handshake fires on phy_tx_valid&phy_tx_ready -> SEND_B1.
- SEND_B1: phy_tx_valid=1, phy_tx_last=1, phy_tx_data=byte1, tx=1. Handshake -> WAIT_DONE, clear counter.
- Handshake rules: valid is held and data stays stable until ready; valid never drops without a handshake, except on reset.
- WAIT_DONE: tx=1, counter increments.
  - phy_tx_done -> pulse complete for 1 cycle, go to IDLE.
  - Counter reaches DONE_TIMEOUT-1 -> pulse discard, go to IDLE.
  - If phy_tx_done and the timeout occur in the same cycle, complete wins.
- rx_msg_valid during SEND_B0, SEND_B1 or WAIT_DONE is ignored.
- Latency: rx_msg_valid at cycle N with bus_idle=1 -> phy_tx_valid=1 at N+2. Minimum of 2 cycles from the byte1 handshake to complete, given phy_tx_done the cycle after.
- Event pulses are registered. They assert in the cycle after the triggering condition, and at most one asserts per cycle.
- phy_tx_done outside WAIT_DONE is ignored.
- tx falls in the same cycle the complete or discard pulse rises.

Decomposition:
- Package tcpc_pkg:
  - state encoding enum goodcrc_tx_state_t
  - constant MSG_TYPE_GOODCRC=5'b00001
  - header field bit-position constants, shared with the Rx header parser
- No sub-module: a single FSM plus one counter and one header register.

Test Plan:
- Basic send: rx_msg_id=3, spec_rev=2'b10, power_role=1, data_role=0, bus_idle=1, phy_tx_ready=1 -> bytes 0x81, then 0x07 with last=1; phy_tx_done 3 cycles later -> exactly one complete pulse; tx=0 afterwards.
- Backpressure: phy_tx_ready low for 5 cycles during SEND_B0 -> phy_tx_valid held at 1 and data held at 0x81 throughout; no byte lost or duplicated.
- Bus busy: bus_idle=0 for 20 cycles with BUS_IDLE_TIMEOUT=16 -> discard pulse 16 cycles after entering WAIT_BUS; phy_tx_valid never asserts.
- Done timeout: no phy_tx_done for 64 cycles -> discard pulse; phy_tx_done arriving on the timeout cycle -> complete only.
- Preemption: second rx_msg_valid with id=5 while in WAIT_BUS -> one discard pulse; the packet later sent carries id=5 (byte1=0x0B for power_role=1).
- Reset mid-SEND_B1 -> all outputs 0 immediately (asynchronously); no event pulse; the next message is handled normally.
